// File: rtl/servo_pwm_driver.sv
// Four-channel hobby-servo PWM generator: a microsecond timebase shared by all
// channels, per-channel angle latch with slew limiting, and registered pulse outputs.

module servo_lane #(
  parameter int unsigned MIN_US     = 500,
  parameter int unsigned US_PER_DEG = 11,
  parameter int unsigned STEP_DEG   = 2,
  parameter int unsigned INIT_DEG   = 90,
  parameter int unsigned CW         = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_edge,
  input  logic          en,
  input  logic [CW-1:0] us_cnt,
  input  logic [7:0]    angle,
  output logic          pwm,
  output logic          at_target
);
  logic [7:0]  cur, tgt_nxt, cur_nxt, diff;
  logic [31:0] width;

  // The target is consumed only at the frame edge where it is latched, so the
  // clamped input feeds the slew step directly and no separate target copy is kept.
  always_comb begin
    tgt_nxt = (angle > 8'd180) ? 8'd180 : angle;
    diff    = (tgt_nxt > cur) ? tgt_nxt - cur : cur - tgt_nxt;
    cur_nxt = tgt_nxt;
    if (STEP_DEG != 0 && 32'(diff) > STEP_DEG)
      cur_nxt = (tgt_nxt > cur) ? cur + 8'(STEP_DEG) : cur - 8'(STEP_DEG);
  end

  assign width = MIN_US + 32'(cur) * US_PER_DEG;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= 8'(INIT_DEG);
      at_target <= 1'b1;
      pwm       <= 1'b0;
    end else begin
      pwm <= en && (32'(us_cnt) < width);
      if (frame_edge) begin
        cur       <= cur_nxt;
        at_target <= (cur_nxt == tgt_nxt);
      end
    end
  end
endmodule

module servo_pwm_driver #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned FRAME_US   = 20000,
  parameter int unsigned MIN_US     = 500,
  parameter int unsigned US_PER_DEG = 11,
  parameter int unsigned STEP_DEG   = 2,
  parameter int unsigned INIT_DEG   = 90
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] angle1,
  input  logic [7:0] angle2,
  input  logic [7:0] angle3,
  input  logic [7:0] angle4,
  input  logic       en,
  output logic [3:0] pwm,
  output logic       frame_start,
  output logic [3:0] at_target
);
  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned TICK      = CLK_HZ / 1_000_000;
  localparam int unsigned PW        = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int unsigned CW        = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;

  logic [PW-1:0]                  presc;
  logic [CW-1:0]                  us_cnt;
  logic                           us_tick, frame_edge;
  logic [NUM_LANES-1:0][7:0]      angles;

  assign angles     = {angle4, angle3, angle2, angle1};
  assign us_tick    = (presc == PW'(TICK - 1));
  assign frame_edge = us_tick && (us_cnt == CW'(FRAME_US - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc       <= '0;
      us_cnt      <= '0;
      frame_start <= 1'b0;
    end else begin
      presc       <= us_tick ? '0 : presc + 1'b1;
      frame_start <= frame_edge;
      if (us_tick) us_cnt <= frame_edge ? '0 : us_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    servo_lane #(
      .MIN_US    (MIN_US),
      .US_PER_DEG(US_PER_DEG),
      .STEP_DEG  (STEP_DEG),
      .INIT_DEG  (INIT_DEG),
      .CW        (CW)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .frame_edge(frame_edge),
      .en        (en),
      .us_cnt    (us_cnt),
      .angle     (angles[i]),
      .pwm       (pwm[i]),
      .at_target (at_target[i])
    );
  end
endmodule

// File: tb/tb_servo_pwm_driver.sv
// Bench for servo_pwm_driver: a jump-mode and a slew-mode instance share inputs and
// are compared every cycle against a time-arithmetic model, plus pulse-width tables.

module tb_servo_pwm_driver;
  localparam int TICK = 2, FUS = 3000, FCLK = TICK * FUS, MINU = 500, UPD = 11;

  logic       clk = 1'b0, rst_n = 1'b0, en = 1'b1;
  logic [7:0] ang [4];
  logic [3:0] pwm0, pwm2, at0, at2;
  logic       fs0, fs2;

  int pass_cnt = 0, total_cnt = 0, mdl_err = 0, diff_prints = 0;
  int k, us_m, cur_m [2][4];
  logic [3:0] at_m [2];
  int w0 [4], w2 [4], flen;

  typedef struct { logic [7:0] ang [4]; int w [4]; } row_t;
  row_t rows [3];

  always #5 clk = ~clk;

  servo_pwm_driver #(.CLK_HZ(2_000_000), .FRAME_US(FUS), .MIN_US(MINU), .US_PER_DEG(UPD),
                     .STEP_DEG(0), .INIT_DEG(90)) dut_jump (
    .clk(clk), .rst_n(rst_n), .angle1(ang[0]), .angle2(ang[1]), .angle3(ang[2]),
    .angle4(ang[3]), .en(en), .pwm(pwm0), .frame_start(fs0), .at_target(at0));

  servo_pwm_driver #(.CLK_HZ(2_000_000), .FRAME_US(FUS), .MIN_US(MINU), .US_PER_DEG(UPD),
                     .STEP_DEG(2), .INIT_DEG(90)) dut_slew (
    .clk(clk), .rst_n(rst_n), .angle1(ang[0]), .angle2(ang[1]), .angle3(ang[2]),
    .angle4(ang[3]), .en(en), .pwm(pwm2), .frame_start(fs2), .at_target(at2));

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int slew(input int c, input int t, input int s);
    int d;
    d = (t > c) ? t - c : c - t;
    if (s == 0 || d <= s) return t;
    return (t > c) ? c + s : c - s;
  endfunction

  // One clock; the model derives the microsecond count and frame edges from the
  // number of clocks since reset release rather than from counters.
  task automatic cyc();
    logic [7:0] a_s [4];
    logic       en_s, r_s, efs;
    logic [3:0] ep [2];
    int         t;
    a_s = ang; en_s = en; r_s = rst_n;
    @(posedge clk); #1;
    efs = 1'b0;
    if (!r_s) begin
      k = 0; us_m = 0;
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < 4; i++) cur_m[d][i] = 90;
        at_m[d] = 4'hf; ep[d] = 4'h0;
      end
    end else begin
      k++;
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 4; i++) ep[d][i] = en_s && (us_m < MINU + cur_m[d][i] * UPD);
      efs = (k % FCLK == 0);
      if (efs)
        for (int d = 0; d < 2; d++)
          for (int i = 0; i < 4; i++) begin
            t = (a_s[i] > 8'd180) ? 180 : int'(a_s[i]);
            cur_m[d][i] = slew(cur_m[d][i], t, (d == 0) ? 0 : 2);
            at_m[d][i]  = (cur_m[d][i] == t);
          end
      us_m = (k / TICK) % FUS;
    end
    if ({pwm0, fs0, at0} !== {ep[0], efs, at_m[0]} || {pwm2, fs2, at2} !== {ep[1], efs, at_m[1]}) begin
      mdl_err++;
      if (diff_prints < 5) begin
        diff_prints++;
        $display("model diff k=%0d jump pwm/fs/at=%b/%b/%b want %b/%b/%b slew %b/%b/%b want %b/%b/%b",
                 k, pwm0, fs0, at0, ep[0], efs, at_m[0], pwm2, fs2, at2, ep[1], efs, at_m[1]);
      end
    end
  endtask

  // Runs until the next frame_start (inclusive), counting high clocks per channel.
  task automatic run_frame(input int chg_at, input int en_off, input int en_on, input bit rnd);
    bit seen;
    int j, rnd_at;
    seen = 1'b0; j = 0;
    rnd_at = rnd ? int'($urandom_range(5900, 0)) : -1;
    for (int i = 0; i < 4; i++) begin w0[i] = 0; w2[i] = 0; end
    while (!seen && j < FCLK + 1000) begin
      if (j == chg_at) ang[3] = 8'd10;
      if (j == rnd_at) ang[1 + $urandom_range(2, 0)] = 8'($urandom_range(255, 0));
      if (j == en_off) begin chk("en_drop_before", int'(pwm0[0]), 1); en = 1'b0; end
      if (j == en_on) en = 1'b1;
      cyc(); j++;
      if (j == en_off + 1) chk("en_drop_after", int'(pwm0[0]), 0);
      for (int i = 0; i < 4; i++) begin w0[i] += int'(pwm0[i]); w2[i] += int'(pwm2[i]); end
      seen = fs0;
    end
    flen = j;
    chk("frame_start_seen", int'(seen), 1);
    chk("model_vs_dut", mdl_err, 0);
    mdl_err = 0;
  endtask

  initial begin
    // Angles set during frame r are measured on the jump instance in frame r+1.
    rows[0].ang = '{8'd0,  8'd180, 8'd200, 8'd100}; rows[0].w = '{1000, 4960, 4960, 3200};
    rows[1].ang = '{8'd45, 8'd135, 8'd1,   8'd179}; rows[1].w = '{1990, 3970, 1022, 4938};
    rows[2].ang = '{8'd0,  8'd90,  8'd180, 8'd255}; rows[2].w = '{1000, 2980, 4960, 4960};

    ang = rows[0].ang; en = 1'b1; rst_n = 1'b0;
    repeat (3) cyc();
    chk("reset_pwm_jump", int'(pwm0), 0);
    chk("reset_pwm_slew", int'(pwm2), 0);
    chk("reset_fs", int'(fs0), 0);
    chk("reset_at_jump", int'(at0), 15);
    chk("reset_at_slew", int'(at2), 15);
    rst_n = 1'b1;

    run_frame(-1, -1, -1, 1'b0);
    chk("first_frame_len", flen, FCLK);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("init_w_jump%0d", i), w0[i], 2980);
      chk($sformatf("init_w_slew%0d", i), w2[i], 2980);
    end

    for (int r = 0; r < 3; r++) begin
      if (r < 2) ang = rows[r + 1].ang;
      run_frame((r == 2) ? 100 : -1, -1, -1, 1'b0);
      chk($sformatf("row%0d_len", r), flen, FCLK);
      for (int i = 0; i < 4; i++) chk($sformatf("row%0d_w%0d", r, i), w0[i], rows[r].w[i]);
    end

    run_frame(-1, -1, -1, 1'b0);
    chk("midchg_new_w3", w0[3], 2 * (MINU + 10 * UPD));
    chk("midchg_w0", w0[0], 1000);

    run_frame(-1, 200, 600, 1'b0);
    chk("en_drop_len", flen, FCLK);
    chk("en_drop_w0", w0[0], 600);

    run_frame(-1, -1, -1, 1'b0);
    chk("en_back_len", flen, FCLK);
    chk("en_back_w0", w0[0], 1000);

    repeat (300) cyc();
    chk("pre_reset_pwm", int'(pwm0), 15);
    rst_n = 1'b0;
    #1;
    chk("async_reset_pwm_jump", int'(pwm0), 0);
    chk("async_reset_pwm_slew", int'(pwm2), 0);
    repeat (3) cyc();
    chk("rst2_at_jump", int'(at0), 15);
    chk("rst2_at_slew", int'(at2), 15);
    chk("rst2_fs", int'(fs2), 0);
    ang[0] = 8'd100;
    rst_n = 1'b1;

    run_frame(-1, -1, -1, 1'b0);
    chk("rst2_first_len", flen, FCLK);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst2_w_jump%0d", i), w0[i], 2980);
      chk($sformatf("rst2_w_slew%0d", i), w2[i], 2980);
    end
    chk("slew_at_edge1", int'(at2[0]), 0);

    for (int f = 1; f <= 5; f++) begin
      run_frame(-1, -1, -1, 1'b1);
      chk($sformatf("slew_w_frame%0d", f), w2[0], 2 * (MINU + UPD * (90 + 2 * f)));
      chk($sformatf("jump_w_frame%0d", f), w0[0], 2 * (MINU + UPD * 100));
      chk($sformatf("slew_at_edge%0d", f + 1), int'(at2[0]), (f >= 4) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
